pid_core_mc: RTL and testbench

- Time-multiplexed, multi-channel successor to the single-channel PID core.
- One shared incremental-form PID datapath serves N_CH independent channels. Each channel has its own setpoint, coefficients, output limits, error/output history, lock enable and clear.
- Sits between the oversample filter (tagged samples in) and the source mux (tagged PID outputs out).
- Adds fixed-point gain scaling, per-channel output clamping with anti-windup, and a ready handshake.

---
 rtl/pid_core_mc.sv | 211 +++++++++++++++++++++
 tb/tb_pid_core_mc.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_core_mc.sv
// pid_core_mc: time-multiplexed incremental PID shared by N_CH channels.
// A sample walks IDLE -> ERR -> MAC -> SAT -> SEND; the result strobes in
// SEND and the channel history is written back at the end of SEND.
// Coefficients live in shadow registers and are copied to the active set
// only while idle, so a sample in flight never sees a coefficient change.
module pid_core_mc #(
   parameter int W_IN       = 18,
   parameter int W_OUT      = 18,
   parameter int W_COEF     = 16,
   parameter int N_CH       = 4,
   parameter int W_CH       = 2,
   parameter int COEF_SHIFT = 8
) (
   input  logic                    clk_in,
   input  logic                    reset_n_in,
   input  logic signed [W_IN-1:0]  data_in,
   input  logic [W_CH-1:0]         chan_in,
   input  logic                    data_valid_in,
   output logic                    ready_out,
   input  logic [W_CH-1:0]         param_chan_in,
   input  logic [2:0]              param_addr_in,
   input  logic [W_OUT-1:0]        param_data_in,
   input  logic                    param_wr_in,
   input  logic                    update_en_in,
   input  logic                    update_in,
   input  logic [N_CH-1:0]         lock_en_in,
   input  logic [N_CH-1:0]         clear_in,
   output logic signed [W_OUT-1:0] data_out,
   output logic [W_CH-1:0]         chan_out,
   output logic                    data_valid_out,
   output logic                    sat_out
);

   localparam int WE = W_IN + 1;     // error width
   localparam int WK = W_COEF + 2;   // combined coefficient width
   localparam int WS = WK + WE + 2;  // MAC sum: three full products
   localparam int WU = WS + 1;       // u_prev + delta, cannot overflow

   localparam logic signed [W_OUT-1:0] OUT_MIN = {1'b1, {(W_OUT-1){1'b0}}};
   localparam logic signed [W_OUT-1:0] OUT_MAX = {1'b0, {(W_OUT-1){1'b1}}};

   typedef enum logic [2:0] {ST_IDLE, ST_ERR, ST_MAC, ST_SAT, ST_SEND} state_t;
   state_t r_state, w_next;

   logic signed [W_IN-1:0]   r_sh_sp  [N_CH];
   logic signed [W_COEF-1:0] r_sh_p   [N_CH];
   logic signed [W_COEF-1:0] r_sh_i   [N_CH];
   logic signed [W_COEF-1:0] r_sh_d   [N_CH];
   logic signed [W_OUT-1:0]  r_sh_min [N_CH];
   logic signed [W_OUT-1:0]  r_sh_max [N_CH];
   logic signed [W_IN-1:0]   r_sp     [N_CH];
   logic signed [W_COEF-1:0] r_p      [N_CH];
   logic signed [W_COEF-1:0] r_i      [N_CH];
   logic signed [W_COEF-1:0] r_d      [N_CH];
   logic signed [W_OUT-1:0]  r_min    [N_CH];
   logic signed [W_OUT-1:0]  r_max    [N_CH];
   logic                     r_pend;

   logic signed [WE-1:0]     r_e1 [N_CH];
   logic signed [WE-1:0]     r_e2 [N_CH];
   logic signed [W_OUT-1:0]  r_up [N_CH];

   logic signed [W_IN-1:0]   r_data;
   logic [W_CH-1:0]          r_ch;
   logic signed [WE-1:0]     r_e;
   logic signed [WS-1:0]     r_delta;
   logic signed [W_OUT-1:0]  r_u;
   logic signed [W_OUT-1:0]  r_dout;
   logic [W_CH-1:0]          r_cout;
   logic                     r_vout;
   logic                     r_sat;

   logic                     w_commit;
   logic                     w_accept;
   logic signed [WE-1:0]     w_e;
   logic signed [WK-1:0]     w_k1, w_k2, w_k3;
   logic signed [WS-1:0]     w_sum, w_delta;
   logic signed [WU-1:0]     w_u;
   logic                     w_hi_sel, w_lo_sel;
   logic signed [W_OUT-1:0]  w_clamp;

   // A pending commit takes the first idle cycle, so ready drops for it.
   assign w_commit  = (r_state == ST_IDLE) && r_pend;
   assign ready_out = reset_n_in && (r_state == ST_IDLE) && !r_pend;
   assign w_accept  = data_valid_in && ready_out;

   assign data_out       = r_dout;
   assign chan_out       = r_cout;
   assign data_valid_out = r_vout;
   assign sat_out        = r_sat;

   // State register.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) r_state <= ST_IDLE;
      else             r_state <= w_next;
   end

   // Next-state: fixed walk through the pipeline once a sample is accepted.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = ST_ERR;
         ST_ERR:  w_next = ST_MAC;
         ST_MAC:  w_next = ST_SAT;
         ST_SAT:  w_next = ST_SEND;
         ST_SEND: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Shadow writes at any time; shadow-to-active copy on commit.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_pend <= 1'b0;
         for (int c = 0; c < N_CH; c++) begin
            r_sh_sp[c] <= '0;  r_sh_p[c] <= '0;  r_sh_i[c] <= '0;  r_sh_d[c] <= '0;
            r_sh_min[c] <= OUT_MIN;  r_sh_max[c] <= OUT_MAX;
            r_sp[c] <= '0;  r_p[c] <= '0;  r_i[c] <= '0;  r_d[c] <= '0;
            r_min[c] <= OUT_MIN;  r_max[c] <= OUT_MAX;
         end
      end else begin
         r_pend <= (r_pend && !w_commit) || (update_in && update_en_in);
         if (w_commit) begin
            for (int c = 0; c < N_CH; c++) begin
               r_sp[c]  <= r_sh_sp[c];
               r_p[c]   <= r_sh_p[c];
               r_i[c]   <= r_sh_i[c];
               r_d[c]   <= r_sh_d[c];
               r_min[c] <= r_sh_min[c];
               r_max[c] <= r_sh_max[c];
            end
         end
         if (param_wr_in) begin
            case (param_addr_in)
               3'd0:    r_sh_sp[param_chan_in]  <= param_data_in[W_IN-1:0];
               3'd1:    r_sh_p[param_chan_in]   <= param_data_in[W_COEF-1:0];
               3'd2:    r_sh_i[param_chan_in]   <= param_data_in[W_COEF-1:0];
               3'd3:    r_sh_d[param_chan_in]   <= param_data_in[W_COEF-1:0];
               3'd4:    r_sh_min[param_chan_in] <= param_data_in;
               3'd5:    r_sh_max[param_chan_in] <= param_data_in;
               default: ;
            endcase
         end
      end
   end

   // Datapath arithmetic for the current channel.
   assign w_e   = WE'(r_sp[r_ch]) - WE'(r_data);
   assign w_k1  = WK'(r_p[r_ch]) + WK'(r_i[r_ch]) + WK'(r_d[r_ch]);
   assign w_k2  = -WK'(r_p[r_ch]) - (WK'(r_d[r_ch]) <<< 1);
   assign w_k3  = WK'(r_d[r_ch]);
   assign w_sum = WS'(w_k1) * WS'(r_e) + WS'(w_k2) * WS'(r_e1[r_ch])
                + WS'(w_k3) * WS'(r_e2[r_ch]);
   assign w_delta = w_sum >>> COEF_SHIFT;
   assign w_u   = WU'(r_up[r_ch]) + WU'(r_delta);

   // Clamp to max, then min; min wins when the limits are inverted.
   always_comb begin
      w_hi_sel = w_u > WU'(r_max[r_ch]);
      w_lo_sel = w_hi_sel ? (r_max[r_ch] < r_min[r_ch]) : (w_u < WU'(r_min[r_ch]));
      w_clamp  = w_u[W_OUT-1:0];
      if (w_hi_sel) w_clamp = r_max[r_ch];
      if (w_lo_sel) w_clamp = r_min[r_ch];
   end

   // Per-stage pipeline registers and registered outputs.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_data <= '0;  r_ch <= '0;  r_e <= '0;  r_delta <= '0;  r_u <= '0;
         r_dout <= '0;  r_cout <= '0;  r_vout <= 1'b0;  r_sat <= 1'b0;
      end else begin
         r_vout <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_accept) begin
               r_data <= data_in;
               r_ch   <= chan_in;
            end
            ST_ERR:  r_e     <= w_e;
            ST_MAC:  r_delta <= w_delta;
            ST_SAT: begin
               r_u    <= lock_en_in[r_ch] ? w_clamp : '0;
               r_dout <= lock_en_in[r_ch] ? w_clamp : '0;
               r_sat  <= lock_en_in[r_ch] && (w_hi_sel || w_lo_sel);
               r_cout <= r_ch;
               r_vout <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Channel history: clear / unlocked channels held at zero, else SEND commit.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         for (int c = 0; c < N_CH; c++) begin
            r_e1[c] <= '0;  r_e2[c] <= '0;  r_up[c] <= '0;
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (clear_in[c] || !lock_en_in[c]) begin
               r_e1[c] <= '0;  r_e2[c] <= '0;  r_up[c] <= '0;
            end else if (r_state == ST_SEND && r_ch == W_CH'(c)) begin
               r_e2[c] <= r_e1[c];
               r_e1[c] <= r_e;
               r_up[c] <= r_u;
            end
         end
      end
   end

endmodule

// File: tb/tb_pid_core_mc.sv
// Scoreboard bench for pid_core_mc: stimulus predicts each accepted sample
// with a plain-arithmetic PID model; a monitor checks every output strobe.
module tb_pid_core_mc;

   logic               clk_in = 1'b0;
   logic               reset_n_in = 1'b0;
   logic signed [17:0] data_in = '0;
   logic [1:0]         chan_in = '0;
   logic               data_valid_in = 1'b0;
   logic               ready_out;
   logic [1:0]         param_chan_in = '0;
   logic [2:0]         param_addr_in = '0;
   logic [17:0]        param_data_in = '0;
   logic               param_wr_in = 1'b0;
   logic               update_en_in = 1'b0;
   logic               update_in = 1'b0;
   logic [3:0]         lock_en_in = 4'hF;
   logic [3:0]         clear_in = '0;
   logic signed [17:0] data_out;
   logic [1:0]         chan_out;
   logic               data_valid_out;
   logic               sat_out;

   pid_core_mc dut (
      .clk_in(clk_in), .reset_n_in(reset_n_in), .data_in(data_in), .chan_in(chan_in),
      .data_valid_in(data_valid_in), .ready_out(ready_out), .param_chan_in(param_chan_in),
      .param_addr_in(param_addr_in), .param_data_in(param_data_in), .param_wr_in(param_wr_in),
      .update_en_in(update_en_in), .update_in(update_in), .lock_en_in(lock_en_in),
      .clear_in(clear_in), .data_out(data_out), .chan_out(chan_out),
      .data_valid_out(data_valid_out), .sat_out(sat_out));

   always #5 clk_in = ~clk_in;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct { int ch; longint d; bit s; int c; } exp_t;
   exp_t q[$];

   // Reference model state: active and shadow parameters, history, pending.
   longint m_sp[4], m_p[4], m_i[4], m_d[4], m_mn[4], m_mx[4];
   longint s_sp[4], s_p[4], s_i[4], s_d[4], s_mn[4], s_mx[4];
   longint m_e1[4], m_e2[4], m_u[4];
   bit     m_pend;

   task automatic chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic longint sx(longint v, int w);
      return (v <<< (64 - w)) >>> (64 - w);
   endfunction

   function automatic void zero_hist(int ch);
      m_e1[ch] = 0; m_e2[ch] = 0; m_u[ch] = 0;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < 4; c++) begin
         m_sp[c] = 0; m_p[c] = 0; m_i[c] = 0; m_d[c] = 0;
         m_mn[c] = -131072; m_mx[c] = 131071;
         s_sp[c] = 0; s_p[c] = 0; s_i[c] = 0; s_d[c] = 0;
         s_mn[c] = -131072; s_mx[c] = 131071;
         zero_hist(c);
      end
      m_pend = 0;
   endfunction

   // Incremental PID: u += floor((p*(e-e1) + i*e + d*(e-2e1+e2)) / 2^8), then clamp.
   function automatic exp_t predict(int ch, longint dat);
      exp_t x;
      longint e, sum, u, v;
      if (m_pend) begin
         m_sp = s_sp; m_p = s_p; m_i = s_i; m_d = s_d; m_mn = s_mn; m_mx = s_mx;
         m_pend = 0;
      end
      x.ch = ch; x.c = cyc;
      if (!lock_en_in[ch]) begin
         zero_hist(ch); x.d = 0; x.s = 0;
         return x;
      end
      e   = m_sp[ch] - dat;
      sum = m_p[ch] * (e - m_e1[ch]) + m_i[ch] * e + m_d[ch] * (e - 2 * m_e1[ch] + m_e2[ch]);
      u   = m_u[ch] + (sum >>> 8);
      v   = u;
      if (v > m_mx[ch]) v = m_mx[ch];
      if (v < m_mn[ch]) v = m_mn[ch];
      x.d = v; x.s = (v != u);
      m_e2[ch] = m_e1[ch]; m_e1[ch] = e; m_u[ch] = v;
      return x;
   endfunction

   // Offer a sample; the model predicts at the accepting edge.
   task automatic send(int ch, longint dat, bit push, bit clr, output int acc);
      int n;
      exp_t x;
      @(negedge clk_in);
      chan_in = 2'(ch); data_in = 18'(dat); data_valid_in = 1'b1;
      if (clr) clear_in[ch] = 1'b1;
      n = 0;
      while (!ready_out && n < 40) begin
         @(negedge clk_in); n++;
      end
      acc = cyc;
      if (!ready_out) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout: got ready=0 expected ready=1 (cycle %0d)", cyc);
      end else if (push) begin
         if (clr) zero_hist(ch);
         x = predict(ch, dat);
         if (clr) zero_hist(ch);
         q.push_back(x);
      end
      @(negedge clk_in);
      data_valid_in = 1'b0;
   endtask

   task automatic send1(int ch, longint dat);
      int acc;
      send(ch, dat, 1'b1, 1'b0, acc);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk_in); n++;
      end
      if (q.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      end
      repeat (2) @(negedge clk_in);
   endtask

   task automatic pwr(int ch, int a, int val);
      @(negedge clk_in);
      param_chan_in = 2'(ch); param_addr_in = 3'(a); param_data_in = 18'(val); param_wr_in = 1'b1;
      case (a)
         0: s_sp[ch] = sx(val, 18);
         1: s_p[ch]  = sx(val, 16);
         2: s_i[ch]  = sx(val, 16);
         3: s_d[ch]  = sx(val, 16);
         4: s_mn[ch] = sx(val, 18);
         5: s_mx[ch] = sx(val, 18);
         default: ;
      endcase
      @(negedge clk_in);
      param_wr_in = 1'b0;
   endtask

   task automatic upd(bit en);
      @(negedge clk_in);
      update_in = 1'b1; update_en_in = en;
      @(negedge clk_in);
      update_in = 1'b0; update_en_in = 1'b0;
      if (en) m_pend = 1;
   endtask

   task automatic clear_pulse(int ch);
      wait_idle();
      clear_in[ch] = 1'b1;
      @(negedge clk_in);
      clear_in[ch] = 1'b0;
      zero_hist(ch);
   endtask

   task automatic set_lock(int ch, bit v);
      wait_idle();
      lock_en_in[ch] = v;
      if (!v) zero_hist(ch);
      @(negedge clk_in);
   endtask

   // Monitor: every strobe must match the oldest prediction.
   always @(negedge clk_in) begin
      exp_t x;
      if (data_valid_out) begin
         if (q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_strobe: got data=%0d ch=%0d expected no strobe", data_out, chan_out);
         end else begin
            x = q.pop_front();
            chk("data_out", 64'(data_out), x.d);
            chk("chan_out", 64'(chan_out), 64'(x.ch));
            chk("sat_out", 64'(sat_out), 64'(x.s));
            chk("latency", 64'(cyc), 64'(x.c + 4));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, n, ch;
      longint dat;
      model_reset();
      #1;
      chk("rst_data_out", 64'(data_out), 0);
      chk("rst_valid", 64'(data_valid_out), 0);
      chk("rst_ready", 64'(ready_out), 0);
      chk("rst_sat", 64'(sat_out), 0);
      repeat (3) @(negedge clk_in);
      reset_n_in = 1'b1;
      @(negedge clk_in);
      chk("ready_after_reset", 64'(ready_out), 1);

      // Proportional gain on ch0.
      pwr(0, 0, 100); pwr(0, 1, 256); upd(1'b1);
      send1(0, 40); send1(0, 40);

      // Integral gain on ch1.
      pwr(1, 0, 100); pwr(1, 2, 256); upd(1'b1);
      send1(1, 40); send1(1, 40); send1(1, 40);

      // Shadow max without update enable must not take effect.
      clear_pulse(1);
      pwr(1, 5, 100); upd(1'b0);
      send1(1, -100);

      // Clamp and anti-windup.
      clear_pulse(1);
      upd(1'b1);
      send1(1, 40); send1(1, 40); send1(1, 40); send1(1, 160);

      // Channel isolation with ch0 clear held across its sample.
      send1(0, 40); send1(1, 160);
      send(0, 40, 1'b1, 1'b1, acc);
      wait_idle();
      clear_in[0] = 1'b0;
      send1(1, 160); send1(0, 40);

      // Unlocked channel outputs zero.
      set_lock(2, 1'b0);
      pwr(2, 0, 100); pwr(2, 1, 256); upd(1'b1);
      send1(2, 40); send1(2, -500);
      set_lock(2, 1'b1);
      send1(2, 40);

      // Update mid-sample: in-flight uses old p, commit cycle blocks ready.
      clear_pulse(0);
      pwr(0, 1, 512);
      send(0, 40, 1'b1, 1'b0, acc);
      upd(1'b1);
      while (cyc < acc + 5) @(negedge clk_in);
      chk("ready_commit_cycle", 64'(ready_out), 0);
      @(negedge clk_in);
      chk("ready_after_commit", 64'(ready_out), 1);
      send1(0, 20);

      // Valid held high: one accept per idle cycle.
      wait_idle();
      chan_in = 2'd1; data_in = 18'(30); data_valid_in = 1'b1;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (ready_out) begin
            q.push_back(predict(1, 30)); n++;
         end
         @(negedge clk_in);
      end
      data_valid_in = 1'b0;
      chk("held_valid_accepts", 64'(n), 4);

      // Reset during MAC abandons the sample.
      wait_idle();
      send1(0, -300);
      wait_idle();
      send(0, 40, 1'b0, 1'b0, acc);
      @(negedge clk_in);
      reset_n_in = 1'b0;
      #1;
      chk("midrst_data_out", 64'(data_out), 0);
      chk("midrst_valid", 64'(data_valid_out), 0);
      chk("midrst_ready", 64'(ready_out), 0);
      chk("midrst_sat", 64'(sat_out), 0);
      chk("midrst_chan", 64'(chan_out), 0);
      model_reset();
      repeat (3) @(negedge clk_in);
      reset_n_in = 1'b1;
      @(negedge clk_in);
      chk("ready_after_midrst", 64'(ready_out), 1);

      // Default limits after reset: zero gains, then full-scale saturation.
      send1(3, 1234);
      pwr(3, 0, 131071); pwr(3, 1, 32767); upd(1'b1);
      send1(3, -131072); send1(3, 131071);

      // Randomized traffic.
      for (int it = 0; it < 80; it++) begin
         ch = int'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            pwr(ch, 0, int'($urandom_range(0, 4000)) - 2000);
            pwr(ch, int'($urandom_range(1, 3)), int'($urandom_range(0, 1024)) - 512);
            if ($urandom_range(0, 5) == 0) begin
               pwr(ch, 4, 300); pwr(ch, 5, -300);
            end else begin
               pwr(ch, 4, -int'($urandom_range(0, 5000)));
               pwr(ch, 5, int'($urandom_range(0, 5000)));
            end
            if ($urandom_range(0, 3) == 0) pwr(ch, int'($urandom_range(6, 7)), 777);
            upd(1'b1);
         end
         if ($urandom_range(0, 7) == 0) clear_pulse(ch);
         if ($urandom_range(0, 9) == 0) set_lock(ch, lock_en_in[ch] ? 1'b0 : 1'b1);
         if ($urandom_range(0, 9) == 0) dat = sx(longint'($urandom), 18);
         else dat = longint'($urandom_range(0, 4000)) - 2000;
         send1(ch, dat);
      end

      wait_idle();
      chk("queue_empty", 64'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
